led_blink_bank: RTL
===================

# led_blink_bank

Multi-channel, parametrised LED driver that replaces the single fixed-rate blinker on the board top level. Each of NUM_CH channels has a runtime-selectable mode (off, on, blink, one-shot pulse) and a programmable half-period, loaded through a valid/ready configuration port. Outputs are registered and polarity-configurable so they drive the on-board LEDs directly.

## Interface
- CLK_FREQ_HZ, 27000000, input clock frequency; sets the reset-default half-period.
- NUM_CH, 6, number of LED channels (1..16).
- CNT_W, 25, half-period counter width; CLK_FREQ_HZ/2-1 must fit, else elaboration $error.
- ACTIVE_LOW, 1, 1 = LED lit when pin low.
- DEFAULT_HALF, CLK_FREQ_HZ/2-1, reset half-period per channel.

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  block can accept a write.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 PULSE.
- cfg_half  in  CNT_W  half-period minus one, in clk cycles.
- led_o  out  NUM_CH  pin drive, registered, polarity per ACTIVE_LOW.
- active_o  out  NUM_CH  channel in BLINK, or PULSE while lit.

## Operation
- Per-channel state: mode (2b), half (CNT_W), cnt (CNT_W), lit (1b).
- Reset: mode=BLINK, half=DEFAULT_HALF, cnt=0, lit=1; cfg_ready=0; led_o all dark (all 1s if ACTIVE_LOW, else 0s); active_o=0.
- Write accepted when cfg_valid && cfg_ready; cfg_ready=1 every cycle after first post-reset edge.
- Accepted write to channel c: mode<=cfg_mode, half<=cfg_half, cnt<=0, lit<=1 (OFF: lit<=0).
- cfg_ch >= NUM_CH: accepted (handshake completes), no state change.
- OFF: lit=0, cnt held 0. ON: lit=1, cnt held 0.
- BLINK: cnt increments; when cnt==half, cnt<=0 and lit toggles. Toggle every half+1 cycles; full period 2*(half+1). half=0 toggles every cycle.
- PULSE FSM: lit=1, cnt counts; when cnt==half, lit<=0, cnt<=0, mode<=OFF. Pulse width exactly half+1 cycles. Single shot; rewrite to retrigger.
- Write to channel in same cycle as its terminal count: write wins, terminal event discarded.
- Channels independent; a write to c never disturbs other channels' cnt or phase.
- led_o[i] <= lit[i] ^ ACTIVE_LOW (after dimming gate if enabled). active_o[i] <= (mode==BLINK) || (mode==PULSE && lit).

## Timing
- Output latency: one register stage; led_o/active_o reflect state of the previous cycle.
- First edge with rst low: state live; led_o shows lit (reset default) one cycle later.
- Write at edge N: new lit visible on led_o at edge N+1 output register, i.e. after edge N+1.
- rst asserted mid-pulse or mid-blink: all channels return to reset state at next edge; pending pulse lost.
- Arithmetic: cnt unsigned CNT_W, never wraps (clears at half); no overflow possible.

## Configuration
- LED_BLINK_DIM_EN: when defined, adds input dim_duty [7:0] and free-running 8-bit pwm counter (reset 0, wraps 255->0). Lit channel drives lit level only when pwm < dim_duty; dim_duty=0 fully dark, 255 lit 255/256 of cycles. Applies to all channels equally. active_o unaffected.
- Undefined: no dim_duty port, no pwm counter; lit channels full brightness.

## Test plan
- Reset release, ACTIVE_LOW=1, DEFAULT_HALF=3 -> led_o all 0 from second post-reset edge; each channel toggles every 4 cycles, period 8; active_o all 1.
- Write ch1 BLINK half=0 -> led_o[1] toggles every cycle starting lit; other channels keep phase.
- Write ch2 PULSE half=4 -> led_o[2] lit exactly 5 cycles, then dark; active_o[2] falls with lit; mode reads OFF thereafter.
- Write ch0 OFF, then ch0 ON -> led_o[0] dark then steady lit, active_o[0]=0 both; write cfg_ch=7 with NUM_CH=6 -> handshake completes, no output change.
- Write ch3 BLINK half=2 coinciding with its terminal count -> cnt restarts 0, lit=1, no toggle that cycle; assert rst mid-pulse -> all outputs dark next cycle.
- LED_BLINK_DIM_EN, channel ON, dim_duty=64 -> led_o lit 64 of every 256 cycles; dim_duty=0 -> never lit.

Source files
------------

// File: rtl/led_blink_bank_if.sv
// Configuration write port for led_blink_bank: one valid/ready handshake carrying
// target channel, mode and half-period.
interface led_blink_bank_if #(
    parameter int NUM_CH = 6,
    parameter int CNT_W  = 25
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [CNT_W-1:0] cfg_half;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_half,
        output cfg_ready
    );
endinterface

// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PULSE with programmable half-period.
// Optional global PWM dimming is compiled in when LED_BLINK_DIM_EN is defined.
module led_blink_bank #(
    parameter int CLK_FREQ_HZ  = 27000000,
    parameter int NUM_CH       = 6,
    parameter int CNT_W        = 25,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEFAULT_HALF = CLK_FREQ_HZ / 2 - 1
) (
    input  logic                clk,
    input  logic                rst,
    led_blink_bank_if.slave     cfg,
`ifdef LED_BLINK_DIM_EN
    input  logic [7:0]          dim_duty,
`endif
    output logic [NUM_CH-1:0]   led_o,
    output logic [NUM_CH-1:0]   active_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEFAULT_HALF);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("led_blink_bank: NUM_CH must be 1..16");
    end
    if (longint'(CLK_FREQ_HZ / 2 - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("led_blink_bank: CNT_W too narrow for CLK_FREQ_HZ/2-1");
    end
    if (longint'(DEFAULT_HALF) >= (longint'(1) << CNT_W) || DEFAULT_HALF < 0) begin : g_bad_default
        $error("led_blink_bank: DEFAULT_HALF does not fit in CNT_W");
    end

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } mode_e;

    mode_e              mode_q [NUM_CH];
    mode_e              mode_n [NUM_CH];
    logic [CNT_W-1:0]   half_q [NUM_CH];
    logic [CNT_W-1:0]   half_n [NUM_CH];
    logic [CNT_W-1:0]   cnt_q  [NUM_CH];
    logic [CNT_W-1:0]   cnt_n  [NUM_CH];
    logic [NUM_CH-1:0]  lit_q;
    logic [NUM_CH-1:0]  lit_n;
    logic               ready_q;
    logic               accept;
    logic               dim_gate;
    logic [NUM_CH-1:0]  led_n;
    logic [NUM_CH-1:0]  act_n;
    logic [NUM_CH-1:0]  led_p1;
    logic [NUM_CH-1:0]  active_p1;

    function automatic logic [NUM_CH-1:0] pin_level(input logic [NUM_CH-1:0] lit);
        return lit ^ {NUM_CH{ACTIVE_LOW}};
    endfunction

    assign cfg.cfg_ready = ready_q;
    assign accept        = cfg.cfg_valid && ready_q;

`ifdef LED_BLINK_DIM_EN
    logic [7:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 8'd0;
        end else begin
            pwm_q <= pwm_q + 8'd1;
        end
    end

    assign dim_gate = (pwm_q < dim_duty);
`else
    assign dim_gate = 1'b1;
`endif

    // Channel state: a write to a channel always overrides that channel's own terminal event.
    always_comb begin
        mode_n = mode_q;
        half_n = half_q;
        cnt_n  = cnt_q;
        lit_n  = lit_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && cfg.cfg_ch == CH_W'(i)) begin
                mode_n[i] = mode_e'(cfg.cfg_mode);
                half_n[i] = cfg.cfg_half;
                cnt_n[i]  = '0;
                lit_n[i]  = (cfg.cfg_mode != MODE_OFF);
            end else begin
                unique case (mode_q[i])
                    MODE_OFF: begin
                        lit_n[i] = 1'b0;
                        cnt_n[i] = '0;
                    end
                    MODE_ON: begin
                        lit_n[i] = 1'b1;
                        cnt_n[i] = '0;
                    end
                    MODE_BLINK: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_n[i] = '0;
                            lit_n[i] = ~lit_q[i];
                        end else begin
                            cnt_n[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                    MODE_PULSE: begin
                        if (cnt_q[i] == half_q[i]) begin
                            cnt_n[i]  = '0;
                            lit_n[i]  = 1'b0;
                            mode_n[i] = MODE_OFF;
                        end else begin
                            cnt_n[i] = cnt_q[i] + CNT_W'(1);
                            lit_n[i] = 1'b1;
                        end
                    end
                    default: begin
                        mode_n[i] = MODE_OFF;
                    end
                endcase
            end
        end
    end

    // Output stage: registered view of the current state, one cycle behind.
    always_comb begin
        led_n = pin_level(lit_q & {NUM_CH{dim_gate}});
        act_n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            act_n[i] = (mode_q[i] == MODE_BLINK) || (mode_q[i] == MODE_PULSE && lit_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_BLINK;
                half_q[i] <= DEF_HALF;
                cnt_q[i]  <= '0;
            end
            lit_q     <= '1;
            ready_q   <= 1'b0;
            led_p1    <= {NUM_CH{ACTIVE_LOW}};
            active_p1 <= '0;
        end else begin
            mode_q    <= mode_n;
            half_q    <= half_n;
            cnt_q     <= cnt_n;
            lit_q     <= lit_n;
            ready_q   <= 1'b1;
            led_p1    <= led_n;
            active_p1 <= act_n;
        end
    end

    assign led_o    = led_p1;
    assign active_o = active_p1;
endmodule
